// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: registered CPU load/store port to N_SLAVES memory-mapped targets.
// Address bits [ADDR_W-1:SLOT_SHIFT] pick the slave; unmapped slots complete with an error.
// Optional wait-state watchdog enabled by defining BUS_TIMEOUT_EN.
module data_bus_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned N_SLAVES   = 4,
  parameter int unsigned SLOT_SHIFT = 10,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cpu_req,
  input  logic                       cpu_we,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  output logic                       cpu_ack,
  output logic                       cpu_err,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic [N_SLAVES-1:0]        s_req,
  output logic                       s_we,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]        s_ready
);

  localparam int unsigned SLOT_W = ADDR_W - SLOT_SHIFT;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]          state;
  logic [1:0]          nextState;
  logic [N_SLAVES-1:0] reqNext;
  logic                weNext;
  logic [ADDR_W-1:0]   addrNext;
  logic [DATA_W-1:0]   wdataNext;
  logic                ackNext;
  logic                errNext;
  logic [DATA_W-1:0]   rdataNext;

  logic [SLOT_W-1:0]   slotIdx;
  logic                slotMapped;
  logic [N_SLAVES-1:0] slotOneHot;
  logic                selReady;
  logic [DATA_W-1:0]   selData;
  logic                timedOut;

  // Decode the incoming address into a slot; full upper-bit compare so high addresses are unmapped
  always_comb begin
    slotIdx    = cpu_addr[ADDR_W-1:SLOT_SHIFT];
    slotMapped = (slotIdx < SLOT_W'(N_SLAVES));
    slotOneHot = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (slotIdx == SLOT_W'(i)) slotOneHot[i] = 1'b1;
    end
  end

  // Ready and read data of the currently selected slave only; other ready bits are ignored
  always_comb begin
    selReady = |(s_ready & s_req);
    selData  = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (s_req[i]) selData = s_rdata[i*DATA_W +: DATA_W];
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] waitCnt;

  // Wait-state counter: zero outside WAIT, counts WAIT cycles without ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if (state != WAIT) begin
      waitCnt <= '0;
    end else if (!selReady) begin
      waitCnt <= waitCnt + CNT_W'(1);
    end
  end

  // Fires on the TIMEOUT-th WAIT cycle so the ack lands TIMEOUT cycles after s_req rose
  always_comb begin
    timedOut = (waitCnt == CNT_W'(TIMEOUT - 1));
  end
`else
  logic unusedTimeout;

  // No watchdog: WAIT lasts until the slave answers
  always_comb begin
    timedOut      = 1'b0;
    unusedTimeout = ^32'(TIMEOUT);
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    nextState = state;
    reqNext   = s_req;
    weNext    = s_we;
    addrNext  = s_addr;
    wdataNext = s_wdata;
    ackNext   = 1'b0;
    errNext   = 1'b0;
    rdataNext = cpu_rdata;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          weNext    = cpu_we;
          addrNext  = cpu_addr;
          wdataNext = cpu_wdata;
          if (slotMapped) begin
            reqNext   = slotOneHot;
            nextState = WAIT;
          end else begin
            nextState = RESP;
            ackNext   = 1'b1;
            errNext   = 1'b1;
            rdataNext = '0;
          end
        end
      end
      WAIT: begin
        if (selReady) begin
          reqNext   = '0;
          nextState = RESP;
          ackNext   = 1'b1;
          rdataNext = s_we ? '0 : selData;
        end else if (timedOut) begin
          reqNext   = '0;
          nextState = RESP;
          ackNext   = 1'b1;
          errNext   = 1'b1;
          rdataNext = '0;
        end
      end
      RESP: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
        reqNext   = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_req     <= '0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      state     <= nextState;
      s_req     <= reqNext;
      s_we      <= weNext;
      s_addr    <= addrNext;
      s_wdata   <= wdataNext;
      cpu_ack   <= ackNext;
      cpu_err   <= errNext;
      cpu_rdata <= rdataNext;
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: the driver pushes the expected response of each
// access into a queue; a negedge monitor pops and compares whenever cpu_ack is seen.
module tb_data_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 4;
  localparam int unsigned SS = 10;
  localparam int unsigned TO = 8;

  logic             clk;
  logic             rst_n;
  logic             cpu_req;
  logic             cpu_we;
  logic [AW-1:0]    cpu_addr;
  logic [DW-1:0]    cpu_wdata;
  logic             cpu_ack;
  logic             cpu_err;
  logic [DW-1:0]    cpu_rdata;
  logic [NS-1:0]    s_req;
  logic             s_we;
  logic [AW-1:0]    s_addr;
  logic [DW-1:0]    s_wdata;
  logic [NS*DW-1:0] s_rdata;
  logic [NS-1:0]    s_ready;

  data_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .N_SLAVES(NS), .SLOT_SHIFT(SS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  typedef struct {
    int            id;
    logic          err;
    logic [DW-1:0] rdata;
    int            ackCyc;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   accId  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && cpu_ack) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got ack err=%0b rdata=%h at cycle %0d, required no ack",
                 cpu_err, cpu_rdata, cyc);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (cpu_err !== e.err || cpu_rdata !== e.rdata || cyc != e.ackCyc) begin
          errors++;
          $display("FAIL ack_%0d: got err=%0b rdata=%h cycle=%0d, required err=%0b rdata=%h cycle=%0d",
                   e.id, cpu_err, cpu_rdata, cyc, e.err, e.rdata, e.ackCyc);
        end
      end
    end
  end

  // Reference: slot is the address divided by the slot size; only slots below NS exist
  function automatic void model(input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] slaveData, output logic mapped,
                                output int slot, output logic [DW-1:0] rdata);
    longint unsigned a;
    a      = longint'(addr);
    slot   = int'(a / (64'd1 << SS));
    mapped = (slot < int'(NS));
    rdata  = (mapped && !we) ? slaveData : '0;
  endfunction

  // One CPU access; called #1 after a rising edge while the DUT is idle
  task automatic access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int delay, input logic [DW-1:0] slaveData,
                        input logic [NS-1:0] spur, input logic neverReady);
    logic          mapped;
    int            slot;
    logic [DW-1:0] mrd;
    logic [NS-1:0] onehot;
    int            nWait;
    exp_t          e;
    model(we, addr, slaveData, mapped, slot, mrd);
    accId++;
    e.id     = accId;
    e.err    = !mapped || neverReady;
    e.rdata  = neverReady ? '0 : mrd;
    e.ackCyc = cyc + (!mapped ? 1 : (neverReady ? int'(TO) + 1 : delay + 1));
    expQ.push_back(e);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    @(posedge clk); #1;
    if (mapped) begin
      onehot = '0;
      onehot[slot] = 1'b1;
      nWait = neverReady ? int'(TO) : delay;
      for (int j = 1; j <= nWait; j++) begin
        checks++;
        if (s_req !== onehot || s_we !== we || s_addr !== addr || s_wdata !== wdata ||
            cpu_ack !== 1'b0) begin
          errors++;
          $display("FAIL wait_hold_%0d_c%0d: got req=%b we=%b addr=%h wdata=%h ack=%b, required req=%b we=%b addr=%h wdata=%h ack=0",
                   accId, j, s_req, s_we, s_addr, s_wdata, cpu_ack, onehot, we, addr, wdata);
        end
        for (int k = 0; k < int'(NS); k++) s_rdata[k*DW +: DW] = $urandom;
        s_ready = spur & ~onehot;
        if (!neverReady && j == delay) begin
          s_rdata[slot*DW +: DW] = slaveData;
          s_ready = s_ready | onehot;
        end
        @(posedge clk); #1;
      end
    end
    s_ready = '0;
    cpu_req = 1'b0;
    checks++;
    if (s_req !== '0 || cpu_ack !== 1'b1) begin
      errors++;
      $display("FAIL resp_%0d: got req=%b ack=%b, required req=0000 ack=1", accId, s_req, cpu_ack);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [AW-1:0] addr;
    logic [AW-1:0] hi;
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    s_rdata   = '0;
    s_ready   = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cpu_ack !== 1'b0 || cpu_err !== 1'b0 || s_req !== '0 || s_we !== 1'b0 ||
        cpu_rdata !== '0 || s_addr !== '0 || s_wdata !== '0) begin
      errors++;
      $display("FAIL reset_state: got ack=%b err=%b req=%b we=%b rdata=%h addr=%h wdata=%h, required all zero",
               cpu_ack, cpu_err, s_req, s_we, cpu_rdata, s_addr, s_wdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    access(1'b0, 32'h0000_0404, 32'h0, 1, 32'hDEAD_BEEF, 4'b0000, 1'b0);
    access(1'b1, 32'h0000_0010, 32'h55, 3, 32'hCAFE_F00D, 4'b0000, 1'b0);
    access(1'b0, 32'h0000_1000, 32'h0, 1, 32'h1111_1111, 4'b0000, 1'b0);
    access(1'b0, 32'h0000_0400, 32'h0, 4, 32'h1234_5678, 4'b1101, 1'b0);
    access(1'b0, 32'hFFFF_F000, 32'h0, 1, 32'h2222_2222, 4'b0000, 1'b0);
    access(1'b0, 32'h0000_0FFF, 32'h0, 2, 32'hA5A5_5A5A, 4'b0111, 1'b0);

    // Reset in the middle of a wait: request must vanish and no ack appear
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_0C00;
    @(posedge clk); #1;
    checks++;
    if (s_req !== 4'b1000) begin
      errors++;
      $display("FAIL pre_reset_req: got req=%b, required 1000", s_req);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_req !== '0 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: got req=%b ack=%b, required req=0000 ack=0", s_req, cpu_ack);
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    access(1'b0, 32'h0000_0C08, 32'h0, 2, 32'h0BAD_F00D, 4'b0000, 1'b0);

`ifdef BUS_TIMEOUT_EN
    access(1'b0, 32'h0000_0800, 32'h0, 1, 32'h3333_3333, 4'b1011, 1'b1);
    access(1'b0, 32'h0000_0800, 32'h0, int'(TO), 32'h4444_4444, 4'b0000, 1'b0);
`endif

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) != 0) begin
        addr = (AW'($urandom_range(0, NS - 1)) << SS) | AW'($urandom_range(0, 1023));
      end else begin
        hi   = AW'($urandom_range(NS, (1 << (AW - SS)) - 1));
        addr = (hi << SS) | AW'($urandom_range(0, 1023));
      end
      access(1'($urandom_range(0, 1)), addr, $urandom, $urandom_range(1, 6), $urandom,
             NS'($urandom), 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL missing_ack: got %0d outstanding, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
